// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: issue/CDB payloads and the multiplier op descriptor.
// Every execution unit and the ROB agree on these widths.
package tomasulo_pkg;

  localparam int XLEN    = 32;
  localparam int MPY_LAT = 4;

  typedef logic [4:0] reg_t;
  typedef logic [3:0] tag_t;
  typedef logic [4:0] robid_t;

  typedef struct packed {
    logic [1:0][XLEN-1:0] rdata;
    reg_t                 wa;
    tag_t                 tag;
    robid_t               robid;
  } issue_t;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] wdata;
    reg_t            wa;
    tag_t            tag;
    robid_t          robid;
  } cdb_t;

  typedef struct packed {
    logic sgn;
    logic hi;
  } mpy_op_t;

endpackage

// File: rtl/tomasulo_mpy_cq.sv
// In-order completion queue for the multiplier; the registered head is the
// unit's CDB output and reads as all-zero whenever the queue is empty.
module tomasulo_mpy_cq
  import tomasulo_pkg::*;
#(
  parameter int Q = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  cdb_t push_data,
  input  logic pop,
  output cdb_t head
);

  localparam int AW = (Q > 1) ? $clog2(Q) : 1;
  localparam int CW = $clog2(Q + 1);
  localparam logic [AW-1:0] LAST = AW'(Q - 1);
  localparam logic [CW-1:0] QC   = CW'(Q);

  cdb_t          mem [Q];
  logic [AW-1:0] rd, wr, rd_n, wr_n;
  logic [CW-1:0] cnt, cnt_pop, cnt_n;
  cdb_t          head_n;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // A push into a queue that is empty after this cycle's pop bypasses
  // storage so the head is valid the very next cycle.
  always_comb begin
    cnt_pop = cnt - CW'(pop);
    cnt_n   = cnt_pop + CW'(push);
    rd_n    = pop ? nxt(rd) : rd;
    wr_n    = push ? nxt(wr) : wr;
    head_n  = '0;
    if (cnt_n != '0) head_n = (push && cnt_pop == '0) ? push_data : mem[rd_n];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd   <= '0;
      wr   <= '0;
      cnt  <= '0;
      head <= '0;
    end else begin
      rd   <= rd_n;
      wr   <= wr_n;
      cnt  <= cnt_n;
      head <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && cnt == QC));

endmodule

// File: rtl/tomasulo_exe_mpy_pipe.sv
// Fully pipelined W x W multiplier execution unit with credit-based issue
// back-pressure and an in-order result queue feeding the CDB.
module tomasulo_exe_mpy_pipe
  import tomasulo_pkg::*;
#(
  parameter int W   = XLEN,  // must not exceed XLEN
  parameter int LAT = MPY_LAT,
  parameter int Q   = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    iss_vld,
  input  issue_t  iss,
  input  mpy_op_t iss_op,
  output logic    iss_busy_r,
  input  logic    flush,
  output cdb_t    cdb_r,
  input  logic    cdb_gnt
);

  localparam int CW = $clog2(Q + 1);
  localparam logic [CW-1:0] QC = CW'(Q);

  logic           acc, gnt;
  logic [W-1:0]   opa, opb;
  logic [2*W-1:0] a_ext, b_ext, prod;
  cdb_t           stage_in;
  logic [LAT-1:0] sv;
  cdb_t           sp [LAT];
  logic [CW-1:0]  occ, occ_n;

  assign acc = iss_vld & ~iss_busy_r & ~flush;
  assign gnt = cdb_gnt & cdb_r.vld & ~flush;

  assign opa = iss.rdata[0][W-1:0];
  assign opb = iss.rdata[1][W-1:0];

  // Low 2W bits of the extended-operand product are exact for both signed
  // and unsigned interpretations.
  always_comb begin
    a_ext          = iss_op.sgn ? {{W{opa[W-1]}}, opa} : {{W{1'b0}}, opa};
    b_ext          = iss_op.sgn ? {{W{opb[W-1]}}, opb} : {{W{1'b0}}, opb};
    prod           = a_ext * b_ext;
    stage_in       = '0;
    stage_in.vld   = 1'b1;
    stage_in.wdata = XLEN'(iss_op.hi ? prod[2*W-1:W] : prod[W-1:0]);
    stage_in.wa    = iss.wa;
    stage_in.tag   = iss.tag;
    stage_in.robid = iss.robid;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) sv <= '0;
    else              sv <= {sv[LAT-2:0], acc};
  end

  always_ff @(posedge clk) begin
    sp[0] <= stage_in;
    for (int i = 1; i < LAT; i++) sp[i] <= sp[i-1];
  end

  // Credits cover both in-flight stages and queued results, so the queue
  // can never be full when a result leaves the last stage.
  always_comb begin
    occ_n = occ;
    case ({acc, gnt})
      2'b10:   occ_n = occ + 1'b1;
      2'b01:   occ_n = occ - 1'b1;
      default: occ_n = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ        <= '0;
      iss_busy_r <= 1'b0;
    end else begin
      occ        <= occ_n;
      iss_busy_r <= (occ_n >= QC);
    end
  end

  tomasulo_mpy_cq #(.Q(Q)) u_cq (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (sv[LAT-1]),
    .push_data (sp[LAT-1]),
    .pop       (gnt),
    .head      (cdb_r)
  );

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ <= QC);

endmodule
